// File: rtl/gfx_arb_pkg.sv
// Shared types and constants for the graphics ROM arbiter.
// The optional result cache is selected with the GFX_ARB_CACHE_EN macro.
package gfx_arb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} arb_state_t;

  typedef enum logic {REQ_SPR, REQ_TILE} req_id_t;

  // Default watchdog limit and the counter width it needs (counts 0..TIMEOUT-1).
  localparam int GFX_ARB_TIMEOUT = 64;
  localparam int WD_W = $clog2(GFX_ARB_TIMEOUT);

  function automatic int wd_width(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/gfx_arb_port.sv
// Per-requester state for the graphics ROM arbiter: tracks whether the
// current address has already been acknowledged, holds the returned data
// and, when GFX_ARB_CACHE_EN is defined, a one-entry address tag.
module gfx_arb_port
  import gfx_arb_pkg::*;
#(
  parameter int AW = 19,
  parameter int DW = 32
) (
  input  logic          clk_main,
  input  logic          reset,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic          cap_en,
  input  logic          abort,
  input  logic [DW-1:0] cap_data,
  input  logic          ack,
  input  logic [AW-1:0] txn_addr,
  output logic          eligible,
  output logic          hit,
  output logic [DW-1:0] data
);

  logic          ack_done_reg;
  logic [AW-1:0] done_addr_reg;
  logic [DW-1:0] data_reg;

  // Remember the address that was last acknowledged; forget it once the
  // requester drops its request or moves to another address.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      ack_done_reg  <= 1'b0;
      done_addr_reg <= '0;
    end else if (ack) begin
      ack_done_reg  <= 1'b1;
      done_addr_reg <= txn_addr;
    end else if (!req || (addr != done_addr_reg)) begin
      ack_done_reg  <= 1'b0;
    end
  end

  // Data hold register: loaded on completion, zeroed on a watchdog abort.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      data_reg <= '0;
    end else if (cap_en) begin
      data_reg <= cap_data;
    end else if (abort) begin
      data_reg <= '0;
    end
  end

  assign eligible = req && !(ack_done_reg && (addr == done_addr_reg));
  assign data     = data_reg;

`ifdef GFX_ARB_CACHE_EN
  logic [AW-1:0] tag_reg;
  logic          valid_reg;

  // One-entry tag: the held data is valid for tag_reg until an abort.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      tag_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (cap_en) begin
      tag_reg   <= txn_addr;
      valid_reg <= 1'b1;
    end else if (abort) begin
      valid_reg <= 1'b0;
    end
  end

  assign hit = valid_reg && (tag_reg == addr);
`else
  assign hit = 1'b0;
`endif

endmodule

// File: rtl/gfx_rom_arbiter.sv
// Shares one SDRAM read port between the sprite and tile ROM requesters.
// Round-robin arbitration, one outstanding read, and a watchdog that aborts
// a read that never completes. Define GFX_ARB_CACHE_EN to enable a
// one-entry per-requester cache that answers repeated addresses locally.
module gfx_rom_arbiter
  import gfx_arb_pkg::*;
#(
  parameter int AW      = 19,
  parameter int DW      = 32,
  parameter int TIMEOUT = GFX_ARB_TIMEOUT
) (
  input  logic          clk_main,
  input  logic          reset,
  input  logic          spr_req,
  input  logic [AW-1:0] spr_addr,
  output logic          spr_ack,
  output logic [DW-1:0] spr_data,
  input  logic          tile_req,
  input  logic [AW-1:0] tile_addr,
  output logic          tile_ack,
  output logic [DW-1:0] tile_data,
  output logic          sd_rd,
  output logic [AW-1:0] sd_addr,
  input  logic          sd_rdy,
  input  logic [DW-1:0] sd_dout,
  output logic          timeout_err
);

  localparam int WD_BITS = (TIMEOUT == GFX_ARB_TIMEOUT) ? WD_W : wd_width(TIMEOUT);

  arb_state_t         state_reg;
  req_id_t            grant_reg;
  req_id_t            last_grant_reg;
  req_id_t            pick;
  logic [WD_BITS-1:0] wd_reg;
  logic               sd_rd_reg;
  logic [AW-1:0]      sd_addr_reg;
  logic               spr_ack_reg;
  logic               tile_ack_reg;
  logic               timeout_err_reg;

  logic               spr_elig, spr_hit, tile_elig, tile_hit;
  logic               pick_hit;
  logic [AW-1:0]      pick_addr;
  logic               wd_expired;
  logic               rdy_now, abort_now;

  assign wd_expired = (wd_reg == WD_BITS'(TIMEOUT - 1));
  assign rdy_now    = (state_reg == WAIT) && sd_rdy;
  assign abort_now  = (state_reg == WAIT) && !sd_rdy && wd_expired;

  // Round-robin choice: on a tie the requester not granted last time wins.
  always_comb begin
    pick = REQ_TILE;
    if (spr_elig && tile_elig) begin
      pick = (last_grant_reg == REQ_SPR) ? REQ_TILE : REQ_SPR;
    end else if (spr_elig) begin
      pick = REQ_SPR;
    end
    pick_hit  = (pick == REQ_SPR) ? spr_hit  : tile_hit;
    pick_addr = (pick == REQ_SPR) ? spr_addr : tile_addr;
  end

  // Arbitration FSM with registered strobes, acks, address and error flag.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      state_reg       <= IDLE;
      grant_reg       <= REQ_SPR;
      last_grant_reg  <= REQ_TILE;
      wd_reg          <= '0;
      sd_rd_reg       <= 1'b0;
      sd_addr_reg     <= '0;
      spr_ack_reg     <= 1'b0;
      tile_ack_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      sd_rd_reg    <= 1'b0;
      spr_ack_reg  <= 1'b0;
      tile_ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (spr_elig || tile_elig) begin
            grant_reg   <= pick;
            sd_addr_reg <= pick_addr;
            wd_reg      <= '0;
            if (pick_hit) begin
              // Cached answer: acknowledge from the held data, no SDRAM read.
              spr_ack_reg  <= (pick == REQ_SPR);
              tile_ack_reg <= (pick == REQ_TILE);
              state_reg    <= DONE;
            end else begin
              sd_rd_reg <= 1'b1;
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (sd_rdy) begin
            spr_ack_reg    <= (grant_reg == REQ_SPR);
            tile_ack_reg   <= (grant_reg == REQ_TILE);
            last_grant_reg <= grant_reg;
            state_reg      <= DONE;
          end else if (wd_expired) begin
            spr_ack_reg     <= (grant_reg == REQ_SPR);
            tile_ack_reg    <= (grant_reg == REQ_TILE);
            timeout_err_reg <= 1'b1;
            state_reg       <= DONE;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  gfx_arb_port #(.AW(AW), .DW(DW)) u_spr_port (
    .clk_main (clk_main),
    .reset    (reset),
    .req      (spr_req),
    .addr     (spr_addr),
    .cap_en   (rdy_now && (grant_reg == REQ_SPR)),
    .abort    (abort_now && (grant_reg == REQ_SPR)),
    .cap_data (sd_dout),
    .ack      (spr_ack_reg),
    .txn_addr (sd_addr_reg),
    .eligible (spr_elig),
    .hit      (spr_hit),
    .data     (spr_data)
  );

  gfx_arb_port #(.AW(AW), .DW(DW)) u_tile_port (
    .clk_main (clk_main),
    .reset    (reset),
    .req      (tile_req),
    .addr     (tile_addr),
    .cap_en   (rdy_now && (grant_reg == REQ_TILE)),
    .abort    (abort_now && (grant_reg == REQ_TILE)),
    .cap_data (sd_dout),
    .ack      (tile_ack_reg),
    .txn_addr (sd_addr_reg),
    .eligible (tile_elig),
    .hit      (tile_hit),
    .data     (tile_data)
  );

  assign sd_rd       = sd_rd_reg;
  assign sd_addr     = sd_addr_reg;
  assign spr_ack     = spr_ack_reg;
  assign tile_ack    = tile_ack_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Self-checking bench for gfx_rom_arbiter: a table of transactions driven
// through a small SDRAM responder, plus hand-written corner sequences.
// Build with GFX_ARB_CACHE_EN defined to exercise the cache path.
module tb_gfx_rom_arbiter;

  localparam int AW      = 19;
  localparam int DW      = 32;
  localparam int TIMEOUT = 64;

  logic          clk_main = 1'b0;
  logic          reset;
  logic          spr_req, tile_req;
  logic [AW-1:0] spr_addr, tile_addr;
  logic          spr_ack, tile_ack;
  logic [DW-1:0] spr_data, tile_data;
  logic          sd_rd, sd_rdy;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_dout;
  logic          timeout_err;

  gfx_rom_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_main    (clk_main),
    .reset       (reset),
    .spr_req     (spr_req),
    .spr_addr    (spr_addr),
    .spr_ack     (spr_ack),
    .spr_data    (spr_data),
    .tile_req    (tile_req),
    .tile_addr   (tile_addr),
    .tile_ack    (tile_ack),
    .tile_data   (tile_data),
    .sd_rd       (sd_rd),
    .sd_addr     (sd_addr),
    .sd_rdy      (sd_rdy),
    .sd_dout     (sd_dout),
    .timeout_err (timeout_err)
  );

  always #5 clk_main = ~clk_main;

  typedef struct {
    logic          spr_req;
    logic [AW-1:0] spr_addr;
    logic          tile_req;
    logic [AW-1:0] tile_addr;
    int            delay;     // cycles from sd_rd to sd_rdy; -1 = withhold
    logic [DW-1:0] rdata;
    logic          exp_tile;  // 0: sprite acked, 1: tile acked
    logic [AW-1:0] exp_addr;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic          is_tile;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  int n_total  = 0;
  int n_passed = 0;
  int rd_cnt   = 0;
  int spr_cnt  = 0;
  int tile_cnt = 0;

  // Pulse counters, sampled at the edge that ends each cycle.
  always @(posedge clk_main) begin
    if (sd_rd)    rd_cnt   <= rd_cnt + 1;
    if (spr_ack)  spr_cnt  <= spr_cnt + 1;
    if (tile_ack) tile_cnt <= tile_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      n_passed++;
  endtask

  task automatic wait_sd_rd(input string name, output int n);
    n = 0;
    while (!sd_rd && n < 20) begin
      @(negedge clk_main);
      n++;
    end
    if (!sd_rd) begin
      $display("FAIL %s: no sd_rd within 20 cycles", name);
      $fatal(1, "bench stopped: arbiter never issued a read");
    end
  endtask

  // Drive one vector, serve the SDRAM read, then check the acknowledgement.
  task automatic run_txn(input int idx, input vec_t v);
    int   n;
    exp_t e;
    logic [DW-1:0] got_data;
    spr_req   = v.spr_req;
    spr_addr  = v.spr_addr;
    tile_req  = v.tile_req;
    tile_addr = v.tile_addr;
    e.is_tile = v.exp_tile;
    e.data    = (v.delay < 0) ? '0 : v.rdata;
    e.err     = v.exp_err;
    sb.push_back(e);
    wait_sd_rd($sformatf("v%0d_sd_rd", idx), n);
    check($sformatf("v%0d_sd_addr", idx), 64'(sd_addr), 64'(v.exp_addr));
    if (v.delay >= 0) begin
      repeat (v.delay) @(negedge clk_main);
      sd_rdy  = 1'b1;
      sd_dout = v.rdata;
      @(negedge clk_main);
      sd_rdy  = 1'b0;
      sd_dout = '0;
    end else begin
      n = 0;
      do begin
        @(negedge clk_main);
        n++;
      end while (!(spr_ack || tile_ack) && n < 100);
      check($sformatf("v%0d_abort_latency", idx), 64'(n), 64'(TIMEOUT));
    end
    e = sb.pop_front();
    got_data = e.is_tile ? tile_data : spr_data;
    $display("txn %0d: spr_ack=%0b tile_ack=%0b sd_addr=0x%05h data=0x%08h err=%0b",
             idx, spr_ack, tile_ack, sd_addr, got_data, timeout_err);
    check($sformatf("v%0d_ack", idx), 64'(e.is_tile ? tile_ack : spr_ack), 64'd1);
    check($sformatf("v%0d_other_ack", idx), 64'(e.is_tile ? spr_ack : tile_ack), 64'd0);
    check($sformatf("v%0d_data", idx), 64'(got_data), 64'(e.data));
    check($sformatf("v%0d_err", idx), 64'(timeout_err), 64'(e.err));
  endtask

  initial begin
    int   n;
    logic any_ack;
    vec_t v;

    // Round robin from reset, then single-requester and watchdog cases.
    vecs[0] = '{1'b1, 19'h00010, 1'b1, 19'h00020,  2, 32'h1000_0010, 1'b0, 19'h00010, 1'b0};
    vecs[1] = '{1'b1, 19'h00011, 1'b1, 19'h00020,  1, 32'h2000_0020, 1'b1, 19'h00020, 1'b0};
    vecs[2] = '{1'b1, 19'h00011, 1'b1, 19'h00021,  0, 32'h1000_0011, 1'b0, 19'h00011, 1'b0};
    vecs[3] = '{1'b1, 19'h00012, 1'b1, 19'h00021,  3, 32'h2000_0021, 1'b1, 19'h00021, 1'b0};
    vecs[4] = '{1'b1, 19'h00012, 1'b1, 19'h00022,  1, 32'h1000_0012, 1'b0, 19'h00012, 1'b0};
    vecs[5] = '{1'b1, 19'h00012, 1'b1, 19'h00022,  2, 32'h2000_0022, 1'b1, 19'h00022, 1'b0};
    vecs[6] = '{1'b1, 19'h12345, 1'b0, 19'h00000,  5, 32'hDEAD_BEEF, 1'b0, 19'h12345, 1'b0};
    vecs[7] = '{1'b0, 19'h00000, 1'b1, 19'h00100, 63, 32'hCAFE_F00D, 1'b1, 19'h00100, 1'b0};
    vecs[8] = '{1'b1, 19'h0ABCD, 1'b0, 19'h00000, -1, 32'h0000_0000, 1'b0, 19'h0ABCD, 1'b1};

    reset = 1'b1;
    spr_req = 1'b0; tile_req = 1'b0;
    spr_addr = '0;  tile_addr = '0;
    sd_rdy = 1'b0;  sd_dout = '0;
    repeat (3) @(negedge clk_main);
    reset = 1'b0;
    check("rst_spr_ack", 64'(spr_ack), 64'd0);
    check("rst_tile_ack", 64'(tile_ack), 64'd0);
    check("rst_spr_data", 64'(spr_data), 64'd0);
    check("rst_tile_data", 64'(tile_data), 64'd0);
    check("rst_sd_rd", 64'(sd_rd), 64'd0);
    check("rst_sd_addr", 64'(sd_addr), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);

    // First sprite request from idle: sd_rd exactly one cycle after req.
    for (int i = 0; i < 9; i++) begin
      run_txn(i, vecs[i]);
      if (i == 5) check("rr_one_rd_per_grant", 64'(rd_cnt), 64'd6);
    end

    // A late sd_rdy after the abort must be discarded.
    repeat (10) @(negedge clk_main);
    sd_rdy = 1'b1; sd_dout = 32'h5555_5555;
    @(negedge clk_main);
    sd_rdy = 1'b0; sd_dout = '0;
    any_ack = spr_ack | tile_ack;
    @(negedge clk_main);
    any_ack = any_ack | spr_ack | tile_ack;
    $display("late sd_rdy: ack=%0b spr_data=0x%08h err=%0b", any_ack, spr_data, timeout_err);
    check("late_rdy_no_ack", 64'(any_ack), 64'd0);
    check("late_rdy_data", 64'(spr_data), 64'd0);
    check("late_rdy_err_sticky", 64'(timeout_err), 64'd1);
    check("late_rdy_no_rd", 64'(rd_cnt), 64'd9);
    spr_req = 1'b0;

    // Reset in the middle of WAIT; sd_rdy two cycles after release is ignored.
    tile_req = 1'b1; tile_addr = 19'h00333;
    wait_sd_rd("rst_wait_sd_rd", n);
    repeat (3) @(negedge clk_main);
    reset = 1'b1; tile_req = 1'b0;
    repeat (2) @(negedge clk_main);
    reset = 1'b0;
    repeat (2) @(negedge clk_main);
    sd_rdy = 1'b1; sd_dout = 32'h7777_7777;
    @(negedge clk_main);
    sd_rdy = 1'b0; sd_dout = '0;
    any_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      any_ack = any_ack | spr_ack | tile_ack | sd_rd;
      @(negedge clk_main);
    end
    $display("reset mid-wait: activity=%0b tile_data=0x%08h err=%0b", any_ack, tile_data, timeout_err);
    check("rstw_no_ack_or_rd", 64'(any_ack), 64'd0);
    check("rstw_tile_data", 64'(tile_data), 64'd0);
    check("rstw_spr_data", 64'(spr_data), 64'd0);
    check("rstw_sd_addr", 64'(sd_addr), 64'd0);
    check("rstw_err_cleared", 64'(timeout_err), 64'd0);
    check("rstw_rd_count", 64'(rd_cnt), 64'd10);

    // Repeated tile address: served from the cache when enabled.
    v = '{1'b0, 19'h00000, 1'b1, 19'h00100, 2, 32'h0BAD_F00D, 1'b1, 19'h00100, 1'b0};
    run_txn(9, v);
    tile_req = 1'b0;
    repeat (2) @(negedge clk_main);
`ifdef GFX_ARB_CACHE_EN
    tile_req = 1'b1;
    @(negedge clk_main);
    $display("cache hit: tile_ack=%0b tile_data=0x%08h", tile_ack, tile_data);
    check("cache_hit_ack", 64'(tile_ack), 64'd1);
    check("cache_hit_data", 64'(tile_data), 64'h0BAD_F00D);
    check("cache_hit_no_rd", 64'(rd_cnt), 64'd11);
`else
    v = '{1'b0, 19'h00000, 1'b1, 19'h00100, 1, 32'h1357_9BDF, 1'b1, 19'h00100, 1'b0};
    run_txn(10, v);
`endif
    v = '{1'b0, 19'h00000, 1'b1, 19'h00101, 4, 32'h2468_ACE0, 1'b1, 19'h00101, 1'b0};
    run_txn(11, v);

    repeat (3) @(negedge clk_main);
`ifdef GFX_ARB_CACHE_EN
    check("total_sd_rd", 64'(rd_cnt), 64'd12);
`else
    check("total_sd_rd", 64'(rd_cnt), 64'd13);
`endif
    check("total_spr_ack", 64'(spr_cnt), 64'd5);
    check("total_tile_ack", 64'(tile_cnt), 64'd7);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
